// File: rtl/conv_layer_sequencer.sv
// Load-and-compute sequencer for Sub_top_CONV: streams IFM/weights into BRAM, paces PE windows
// and captures OFM words. Define CONV_SEQ_OFM_FIFO_EN to buffer OFM words in a FWFT FIFO.
module conv_layer_sequencer #(
  parameter int unsigned NUM_PE        = 16,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned OFM_W         = 8,
  parameter int unsigned IFM_WORDS     = 12544,
  parameter int unsigned WEIGHT_WORDS  = 72,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned WIN_CYCLES    = 36,
  parameter int unsigned NUM_WIN       = 100,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    ifm_we,
  output logic [NUM_PE-1:0]       wt_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_data,
  output logic                    cal_start,
  output logic [NUM_PE-1:0]       PE_en,
  output logic [NUM_PE-1:0]       PE_finish,
  input  logic [NUM_PE-1:0]       pe_valid,
  input  logic [NUM_PE*OFM_W-1:0] pe_ofm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_PE*OFM_W-1:0] out_data,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int unsigned OW = NUM_PE * OFM_W;

  typedef enum logic [2:0] {
    StIdle, StLoadIfm, StLoadWt, StSettle, StWin, StDone
  } state_e;

  state_e              r_state, w_state_next;
  logic [31:0]         r_cnt, r_pe, r_win;
  logic                r_ifm_we;
  logic [NUM_PE-1:0]   r_wt_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                w_start_ok, w_beat, w_all_valid;
  logic                w_last_ifm, w_last_wt_word, w_last_pe, w_last_settle;
  logic                w_last_cycle, w_last_win;
  logic [NUM_PE-1:0]   w_wt_onehot;

  assign w_start_ok     = start && (r_state == StIdle || r_state == StDone);
  assign w_beat         = in_valid && in_ready;
  assign w_all_valid    = &pe_valid;
  assign w_last_ifm     = (r_cnt == IFM_WORDS - 1);
  assign w_last_wt_word = (r_cnt == WEIGHT_WORDS - 1);
  assign w_last_pe      = (r_pe == NUM_PE - 1);
  assign w_last_settle  = (r_cnt == SETTLE_CYCLES - 1);
  assign w_last_cycle   = (r_cnt == WIN_CYCLES - 1);
  assign w_last_win     = (r_win == NUM_WIN - 1);
  assign w_wt_onehot    = {{(NUM_PE-1){1'b0}}, 1'b1} << r_pe;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    cal_start    = 1'b0;
    PE_en        = '0;
    PE_finish    = '0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: if (start) w_state_next = StLoadIfm;
      StLoadIfm: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && w_last_ifm) w_state_next = StLoadWt;
      end
      StLoadWt: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && w_last_wt_word && w_last_pe) w_state_next = StSettle;
      end
      StSettle: begin
        cal_start = 1'b1;
        busy      = 1'b1;
        if (w_last_settle) w_state_next = StWin;
      end
      StWin: begin
        cal_start = 1'b1;
        busy      = 1'b1;
        PE_en     = (r_cnt == 32'd0) ? '1 : '0;
        PE_finish = w_last_cycle ? '1 : '0;
        if (w_last_cycle && w_last_win) w_state_next = StDone;
      end
      StDone: begin
        done = 1'b1;
        if (start) w_state_next = StLoadIfm;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // r_cnt is reused: beat index, weight word, settle count, window cycle.
  always_ff @(posedge clk) begin
    if (!reset || w_start_ok) begin
      r_cnt <= '0;
      r_pe  <= '0;
      r_win <= '0;
    end else begin
      case (r_state)
        StLoadIfm: if (in_valid) r_cnt <= w_last_ifm ? '0 : r_cnt + 32'd1;
        StLoadWt: begin
          if (in_valid) begin
            if (w_last_wt_word) begin
              r_cnt <= '0;
              r_pe  <= r_pe + 32'd1;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
        end
        StSettle: r_cnt <= w_last_settle ? '0 : r_cnt + 32'd1;
        StWin: begin
          if (w_last_cycle) begin
            r_cnt <= '0;
            r_win <= r_win + 32'd1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ifm_we <= 1'b0;
      r_wt_we  <= '0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_ifm_we <= w_beat && (r_state == StLoadIfm);
      r_wt_we  <= (w_beat && r_state == StLoadWt) ? w_wt_onehot : '0;
      if (w_beat) begin
        r_addr <= r_cnt[ADDR_W-1:0];
        r_data <= in_data;
      end
    end
  end

  assign ifm_we   = r_ifm_we;
  assign wt_we    = r_wt_we;
  assign mem_addr = r_addr;
  assign mem_data = r_data;

`ifdef CONV_SEQ_OFM_FIFO_EN
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [OW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr, r_rptr, w_count;
  logic          r_overflow, w_full, w_push, w_pop;

  assign w_count   = r_wptr - r_rptr;
  assign w_full    = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop     = out_valid && out_ready;
  assign w_push    = w_all_valid && (!w_full || w_pop);
  assign out_valid = (w_count != '0);
  assign out_data  = r_mem[r_rptr[AW-1:0]];
  assign overflow  = r_overflow;

  always_ff @(posedge clk) begin
    if (!reset || w_start_ok) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      if (w_all_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= pe_ofm;
  end
`else
  logic          r_out_valid;
  logic [OW-1:0] r_out_data;
  logic          w_unused_out_ready;

  assign w_unused_out_ready = out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_all_valid;
      if (w_all_valid) r_out_data <= pe_ofm;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign overflow  = 1'b0;
`endif

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Synthesizable load-and-compute controller that sits in front of `Sub_top_CONV` and replaces the hand-driven load and calculation stimulus.
- Accepts one beat stream carrying the IFM followed by per-PE weights, and generates the BRAM write strobes and addresses.
- Drives `cal_start` and the periodic `PE_en`/`PE_finish` window pulses for a programmable number of windows.
- Captures the per-PE OFM bytes whenever all PEs report valid.
- All sizes are parameters, so the same block serves every conv layer of the fused block.

## Interface
- `NUM_PE`, 16, number of PEs / output channels per pass
- `DATA_W`, 32, load-stream and BRAM word width
- `ADDR_W`, 20, BRAM address width
- `OFM_W`, 8, OFM bits per PE
- `IFM_WORDS`, 12544, IFM words to load
- `WEIGHT_WORDS`, 72, weight words per PE
- `SETTLE_CYCLES`, 2, cycles between end of load and first `PE_en`; must be ≥1
- `WIN_CYCLES`, 36, cycles per window; must be ≥3
- `NUM_WIN`, 100, windows per pass
- `FIFO_DEPTH`, 4, OFM FIFO entries; must be a power of two
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  begin a pass; sampled only in IDLE or DONE
- `in_valid`  in  1  load beat valid
- `in_ready`  out  1  load beat accepted when `in_valid && in_ready`
- `in_data`  in  DATA_W  load beat
- `ifm_we`  out  1  IFM BRAM write enable
- `wt_we`  out  NUM_PE  one-hot weight BRAM write enable
- `mem_addr`  out  ADDR_W  word address for the active write
- `mem_data`  out  DATA_W  write data
- `cal_start`  out  1  calculation enable to the datapath
- `PE_en`  out  NUM_PE  window-start pulse
- `PE_finish`  out  NUM_PE  window-end pulse
- `pe_valid`  in  NUM_PE  per-PE OFM valid
- `pe_ofm`  in  NUM_PE*OFM_W  PE p occupies bits [p*OFM_W +: OFM_W]
- `out_valid`  out  1  OFM word available
- `out_ready`  in  1  consumer accepts OFM word
- `out_data`  out  NUM_PE*OFM_W  captured OFM word
- `busy`  out  1  state is not IDLE/DONE
- `done`  out  1  pass complete
- `overflow`  out  1  sticky: an OFM capture was dropped

## Operation
- FSM states: IDLE, LOAD_IFM, LOAD_WT, SETTLE, WIN, DONE.
  - IDLE/DONE --start--> LOAD_IFM. Entering LOAD_IFM clears `done`, `overflow`, all counters and the FIFO.
- LOAD_IFM:
  - `in_ready`=1.
  - Beat k (0..IFM_WORDS-1) produces a write at address k.
  - After beat IFM_WORDS-1 → LOAD_WT.
- LOAD_WT:
  - `in_ready`=1. Data is PE-major: beat index p*WEIGHT_WORDS+w writes PE p at address w, with `wt_we`=1<<p.
  - After the final beat → SETTLE.
- SETTLE:
  - `cal_start` rises on entry and stays 1 through WIN; it drops on entering DONE.
  - Lasts SETTLE_CYCLES cycles.
- WIN: window counter c runs 0..WIN_CYCLES-1.
  - c=0: `PE_en`=all ones.
  - c=WIN_CYCLES-1: `PE_finish`=all ones.
  - Otherwise both are 0.
  - After NUM_WIN windows → DONE.
- DONE: `done`=1, held until the next `start`.
- OFM capture:
  - Active in every state.
  - When `pe_valid` is all ones, push `pe_ofm` into the FIFO.
  - A partial `pe_valid` is ignored.
  - Push when full: the word is dropped and `overflow` is set.
  - Push and pop in the same cycle when full: both proceed, no overflow.
- `start` outside IDLE/DONE is ignored.
- Low `reset` at any time: return to IDLE and clear all state. Partially loaded data is abandoned.

## Timing
- Reset values: `in_ready`, `ifm_we`, `wt_we`, `mem_addr`, `mem_data`, `cal_start`, `PE_en`, `PE_finish`, `out_valid`, `busy`, `done`, `overflow` are all 0.
- Write latency:
  - The beat accepted at edge t appears on `ifm_we`/`wt_we`/`mem_addr`/`mem_data` during cycle t+1, registered.
  - Strobes are 0 in cycles with no accepted beat.
- `in_ready` falls in the cycle after the last weight beat is accepted. There is no back-pressure from the BRAM.
- First `PE_en` occurs SETTLE_CYCLES cycles after `cal_start` rises.
- Window period is exactly WIN_CYCLES cycles. Windows are back-to-back with no gap.
- `done` rises in the cycle after the last `PE_finish`.
- FIFO `out_data` is first-word-fall-through. `out_valid` rises the cycle after the push.

## Configuration
- `CONV_SEQ_OFM_FIFO_EN` defined:
  - OFM path uses the FIFO_DEPTH FIFO with `out_ready` flow control, as above.
- Not defined:
  - No FIFO. `out_data` is the `pe_ofm` registered on the all-valid cycle, and `out_valid` is a one-cycle pulse the next cycle.
  - `out_ready` is ignored and `overflow` is tied to 0.

## Test plan
Common parameters: NUM_PE=4, IFM_WORDS=4, WEIGHT_WORDS=2, SETTLE_CYCLES=2, WIN_CYCLES=6, NUM_WIN=3, FIFO_DEPTH=4.

- Load: beats 0x10..0x13, then 0x20..0x27 → IFM writes at addr 0..3 with data 0x10..0x13; then `wt_we`=1,1,2,2,4,4,8,8 at addr 0,1,0,1,…; `in_ready` low afterwards.
- Load with `in_valid` toggling every other cycle → identical write sequence, no write strobe in gap cycles.
- Compute: `cal_start` rises; `PE_en`=0xF two cycles later; `PE_finish`=0xF 5 cycles after each `PE_en`; 3 windows; `done`=1 the next cycle; `cal_start`=0.
- Capture: `pe_valid`=0xF with `pe_ofm`=0xAABBCCDD, `out_ready`=0 → `out_valid`=1, `out_data`=0xAABBCCDD. Five such pushes → 4 held and `overflow`=1 (FIFO build). `pe_valid`=0x7 → no push.
- Reset asserted low mid-LOAD_WT → all outputs 0 next cycle. A new `start` reloads from IFM addr 0.
- `start` pulsed during WIN → ignored, window count unchanged; `start` in DONE → new pass and `done` clears.
